// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared encodings and frame geometry for the I2S transmit scheduler
//
// Purpose: active_src encodings, arb_mode / urun_mode encodings and the
// frame length derived from the per-channel sample width.
package i2s_pkg;

  typedef enum logic [1:0] {
    SRC_SILENCE = 2'b00,
    SRC_S0      = 2'b01,
    SRC_S1      = 2'b10,
    SRC_REPEAT  = 2'b11
  } active_src_e;

  localparam logic ARB_FIXED   = 1'b0;
  localparam logic ARB_RR      = 1'b1;
  localparam logic URUN_ZERO   = 1'b0;
  localparam logic URUN_REPEAT = 1'b1;

  // One stereo frame is one left plus one right sample, one bit per sclk.
  function automatic int frame_len(input int audio_dw);
    return 2 * audio_dw;
  endfunction

endpackage

// File: rtl/i2s_src_buf.sv
// rtl/i2s_src_buf.sv - one-entry valid/ready buffer for one stereo source
//
// Purpose: holds one offered stereo sample until the scheduler drains it.
// Ports:
//   sclk, rst_n           clock, asynchronous active-low reset
//   valid, left, right    offered sample from the source
//   ready                 registered, high while the entry is empty
//   drain                 scheduler takes the entry this cycle
//   full                  entry holds data
//   buf_left, buf_right   stored sample
module i2s_src_buf #(
  parameter int DW = 32
) (
  input  logic          sclk,
  input  logic          rst_n,
  input  logic          valid,
  input  logic [DW-1:0] left,
  input  logic [DW-1:0] right,
  output logic          ready,
  input  logic          drain,
  output logic          full,
  output logic [DW-1:0] buf_left,
  output logic [DW-1:0] buf_right
);

  logic accept;
  logic full_nxt;

  assign accept = valid & ready;

  // accept and drain never coincide: ready is low whenever full is high.
  always_comb begin
    full_nxt = full;
    if (accept)
      full_nxt = 1'b1;
    else if (drain)
      full_nxt = 1'b0;
  end

  // ready resets low so that no handshake can complete in the first cycle
  // after release; it tracks ~full from the first edge onwards.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      full      <= 1'b0;
      ready     <= 1'b0;
      buf_left  <= '0;
      buf_right <= '0;
    end else begin
      full  <= full_nxt;
      ready <= ~full_nxt;
      if (accept) begin
        buf_left  <= left;
        buf_right <= right;
      end
    end
  end

endmodule

// File: rtl/i2s_tx_sched.sv
// rtl/i2s_tx_sched.sv - frame-synchronous two-source scheduler feeding an I2S transmitter
//
// Purpose: at every frame boundary picks one of two buffered sources (fixed
// priority or round-robin), or silence / repeat on underrun, and presents
// the sample for a whole frame.
// Ports:
//   sclk, rst_n                        clock, asynchronous active-low reset
//   en, arb_mode, urun_mode            boundary behaviour controls
//   s0_*/s1_* valid,ready,left,right   source handshakes and data
//   left_chan, right_chan, active_src  sample for the current frame and its origin
//   frame_tick                         pulse in the cycle outputs change
//   underrun, urun_clr, urun_cnt       sticky flag, clear, saturating count
module i2s_tx_sched
  import i2s_pkg::*;
#(
  parameter int AUDIO_DW = 32
) (
  input  logic                sclk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                arb_mode,
  input  logic                urun_mode,
  input  logic                s0_valid,
  input  logic                s1_valid,
  output logic                s0_ready,
  output logic                s1_ready,
  input  logic [AUDIO_DW-1:0] s0_left,
  input  logic [AUDIO_DW-1:0] s0_right,
  input  logic [AUDIO_DW-1:0] s1_left,
  input  logic [AUDIO_DW-1:0] s1_right,
  output logic [AUDIO_DW-1:0] left_chan,
  output logic [AUDIO_DW-1:0] right_chan,
  output logic [1:0]          active_src,
  output logic                frame_tick,
  output logic                underrun,
  input  logic                urun_clr,
  output logic [15:0]         urun_cnt
);

  localparam int FRAME_LEN = frame_len(AUDIO_DW);
  localparam int CW        = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  logic [CW-1:0]       frame_cnt;
  logic                boundary;
  logic                full0, full1;
  logic                gnt0, gnt1;
  logic                starve;
  logic                last_grant;   // 0 = s0, 1 = s1 granted most recently
  logic [AUDIO_DW-1:0] b0_left, b0_right, b1_left, b1_right;
  logic [AUDIO_DW-1:0] rep_left, rep_right;

  assign boundary = (frame_cnt == LAST_CNT);

  i2s_src_buf #(.DW(AUDIO_DW)) u_buf0 (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .valid     (s0_valid),
    .left      (s0_left),
    .right     (s0_right),
    .ready     (s0_ready),
    .drain     (gnt0),
    .full      (full0),
    .buf_left  (b0_left),
    .buf_right (b0_right)
  );

  i2s_src_buf #(.DW(AUDIO_DW)) u_buf1 (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .valid     (s1_valid),
    .left      (s1_left),
    .right     (s1_right),
    .ready     (s1_ready),
    .drain     (gnt1),
    .full      (full1),
    .buf_left  (b1_left),
    .buf_right (b1_right)
  );

  // s0 wins unless s1 also holds data under round-robin and s0 went last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (boundary && en) begin
      if (full0 && (!full1 || arb_mode == ARB_FIXED || last_grant))
        gnt0 = 1'b1;
      else if (full1)
        gnt1 = 1'b1;
    end
  end

  assign starve = boundary && en && !full0 && !full1;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt  <= '0;
      frame_tick <= 1'b0;
      left_chan  <= '0;
      right_chan <= '0;
      active_src <= SRC_SILENCE;
      rep_left   <= '0;
      rep_right  <= '0;
      last_grant <= 1'b1;
    end else begin
      frame_cnt  <= boundary ? '0 : frame_cnt + 1'b1;
      frame_tick <= boundary;
      if (boundary) begin
        if (gnt0) begin
          left_chan  <= b0_left;
          right_chan <= b0_right;
          rep_left   <= b0_left;
          rep_right  <= b0_right;
          active_src <= SRC_S0;
          last_grant <= 1'b0;
        end else if (gnt1) begin
          left_chan  <= b1_left;
          right_chan <= b1_right;
          rep_left   <= b1_left;
          rep_right  <= b1_right;
          active_src <= SRC_S1;
          last_grant <= 1'b1;
        end else if (starve && urun_mode == URUN_REPEAT) begin
          left_chan  <= rep_left;
          right_chan <= rep_right;
          active_src <= SRC_REPEAT;
        end else begin
          left_chan  <= '0;
          right_chan <= '0;
          active_src <= SRC_SILENCE;
        end
      end
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      underrun <= 1'b0;
      urun_cnt <= '0;
    end else if (urun_clr) begin
      underrun <= 1'b0;
      urun_cnt <= '0;
    end else if (starve) begin
      underrun <= 1'b1;
      if (urun_cnt != 16'hFFFF)
        urun_cnt <= urun_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_i2s_tx_sched.sv
// tb/tb_i2s_tx_sched.sv - self-checking bench for i2s_tx_sched with a frame-level reference model
module tb_i2s_tx_sched;

  localparam int DW = 8;
  localparam int FL = 2 * DW;

  logic          sclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0, arb_mode = 1'b0, urun_mode = 1'b0, urun_clr = 1'b0;
  logic          s0_valid = 1'b0, s1_valid = 1'b0;
  logic [DW-1:0] s0_left = '0, s0_right = '0, s1_left = '0, s1_right = '0;
  logic          s0_ready, s1_ready, frame_tick, underrun;
  logic [DW-1:0] left_chan, right_chan;
  logic [1:0]    active_src;
  logic [15:0]   urun_cnt;

  int checks = 0;
  int failures = 0;

  // reference model state
  int            m_cnt, m_last, m_tick, m_urun, m_ucnt, m_act;
  int            m_full[2], m_rdy[2];
  logic [DW-1:0] m_bl[2], m_br[2], m_l, m_r, m_rl, m_rr;

  i2s_tx_sched #(.AUDIO_DW(DW)) dut (
    .sclk(sclk), .rst_n(rst_n), .en(en), .arb_mode(arb_mode), .urun_mode(urun_mode),
    .s0_valid(s0_valid), .s1_valid(s1_valid), .s0_ready(s0_ready), .s1_ready(s1_ready),
    .s0_left(s0_left), .s0_right(s0_right), .s1_left(s1_left), .s1_right(s1_right),
    .left_chan(left_chan), .right_chan(right_chan), .active_src(active_src),
    .frame_tick(frame_tick), .underrun(underrun), .urun_clr(urun_clr), .urun_cnt(urun_cnt)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_last = 1; m_tick = 0; m_urun = 0; m_ucnt = 0; m_act = 0;
    m_l = '0; m_r = '0; m_rl = '0; m_rr = '0;
    for (int i = 0; i < 2; i++) begin
      m_full[i] = 0; m_rdy[i] = 0; m_bl[i] = '0; m_br[i] = '0;
    end
  endtask

  // One clock edge of the specified behaviour, computed from the rules.
  task automatic model_edge();
    int            bnd, g;
    int            v[2];
    logic [DW-1:0] il[2], ir[2];
    if (!rst_n) begin
      model_reset();
      return;
    end
    v[0] = s0_valid; v[1] = s1_valid;
    il[0] = s0_left; ir[0] = s0_right; il[1] = s1_left; ir[1] = s1_right;
    bnd = (m_cnt == FL - 1);
    g = -1;
    if (bnd && en) begin
      if (m_full[0] && m_full[1]) g = arb_mode ? (m_last == 0 ? 1 : 0) : 0;
      else if (m_full[0]) g = 0;
      else if (m_full[1]) g = 1;
    end
    m_tick = bnd;
    if (bnd) begin
      if (!en) begin
        m_l = '0; m_r = '0; m_act = 0;
      end else if (g >= 0) begin
        m_l = m_bl[g]; m_r = m_br[g]; m_rl = m_bl[g]; m_rr = m_br[g];
        m_act = g + 1; m_last = g;
      end else if (urun_mode) begin
        m_l = m_rl; m_r = m_rr; m_act = 3;
      end else begin
        m_l = '0; m_r = '0; m_act = 0;
      end
    end
    if (urun_clr) begin
      m_urun = 0; m_ucnt = 0;
    end else if (bnd && en && g < 0) begin
      m_urun = 1;
      if (m_ucnt < 16'hFFFF) m_ucnt++;
    end
    for (int i = 0; i < 2; i++) begin
      if (v[i] && m_rdy[i]) begin
        m_full[i] = 1; m_bl[i] = il[i]; m_br[i] = ir[i];
      end else if (g == i) begin
        m_full[i] = 0;
      end
      m_rdy[i] = !m_full[i];
    end
    m_cnt = (m_cnt + 1) % FL;
  endtask

  task automatic compare_all();
    chk("left_chan", 32'(left_chan), 32'(m_l));
    chk("right_chan", 32'(right_chan), 32'(m_r));
    chk("active_src", 32'(active_src), 32'(m_act));
    chk("frame_tick", 32'(frame_tick), 32'(m_tick));
    chk("underrun", 32'(underrun), 32'(m_urun));
    chk("urun_cnt", 32'(urun_cnt), 32'(m_ucnt));
    chk("s0_ready", 32'(s0_ready), 32'(m_rdy[0]));
    chk("s1_ready", 32'(s1_ready), 32'(m_rdy[1]));
  endtask

  task automatic step();
    @(posedge sclk);
    model_edge();
    @(negedge sclk);
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge sclk);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // single source from reset, fixed priority: first frame carries s0
    en = 1; arb_mode = 0; urun_mode = 0;
    s0_valid = 1; s0_left = 8'h11; s0_right = 8'h22;
    repeat (16) step();
    chk("first_tick", 32'(frame_tick), 32'd1);
    chk("first_left", 32'(left_chan), 32'h11);
    chk("first_right", 32'(right_chan), 32'h22);
    chk("first_src", 32'(active_src), 32'd1);
    chk("first_s0_ready", 32'(s0_ready), 32'd1);
    repeat (20) step();

    // both sources always valid: round-robin then fixed priority
    s1_valid = 1; s1_left = 8'h33; s1_right = 8'h44; arb_mode = 1;
    repeat (4 * FL) step();
    arb_mode = 0;
    repeat (3 * FL) step();

    // en low with both buffers full, then re-enable
    en = 0;
    repeat (2 * FL) step();
    en = 1;
    repeat (FL) step();

    // starvation with zero fill, then clear
    do_reset();
    s0_valid = 0; s1_valid = 0; urun_mode = 0;
    repeat (3 * FL) step();
    chk("urun_cnt_3", 32'(urun_cnt), 32'd3);
    chk("underrun_set", 32'(underrun), 32'd1);
    urun_clr = 1;
    step();
    urun_clr = 0;
    chk("urun_cnt_clr", 32'(urun_cnt), 32'd0);
    chk("underrun_clr", 32'(underrun), 32'd0);

    // play s1 once, then starve in repeat mode
    do_reset();
    s1_valid = 1; s1_left = 8'hA5; s1_right = 8'h5A;
    step(); step(); step();
    s1_valid = 0; urun_mode = 1;
    repeat (2 * FL - 3) step();
    chk("repeat_left", 32'(left_chan), 32'hA5);
    chk("repeat_right", 32'(right_chan), 32'h5A);
    chk("repeat_src", 32'(active_src), 32'd3);
    repeat (FL) step();

    // randomized frames
    for (int f = 0; f < 60; f++) begin
      int th0, th1;
      th0 = $urandom_range(0, 15);
      th1 = $urandom_range(0, 15);
      arb_mode  = 1'($urandom_range(0, 1));
      urun_mode = 1'($urandom_range(0, 1));
      for (int c = 0; c < FL; c++) begin
        en       = ($urandom_range(0, 7) != 0);
        urun_clr = ($urandom_range(0, 39) == 0);
        s0_valid = ($urandom_range(0, 15) < th0);
        s1_valid = ($urandom_range(0, 15) < th1);
        s0_left = 8'($urandom); s0_right = 8'($urandom);
        s1_left = 8'($urandom); s1_right = 8'($urandom);
        step();
      end
    end
    urun_clr = 0;

    // asynchronous reset in mid-frame with s0 full
    en = 1; s0_valid = 1; s1_valid = 0;
    for (int k = 0; k < FL && m_cnt != 7; k++) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_left", 32'(left_chan), 32'd0);
    chk("mid_rst_src", 32'(active_src), 32'd0);
    chk("mid_rst_cnt", 32'(urun_cnt), 32'd0);
    chk("mid_rst_urun", 32'(underrun), 32'd0);
    model_reset();
    compare_all();
    step();
    rst_n = 1'b1;
    repeat (15) step();
    chk("rst_no_early_tick", 32'(frame_tick), 32'd0);
    step();
    chk("rst_first_tick", 32'(frame_tick), 32'd1);
    repeat (FL) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_tx_sched.md
I2S_TX_SCHED -- requirements
Module: i2s_tx_sched

Interface
REQ-001 Parameter AUDIO_DW, default 32, width of one channel sample; FRAME_LEN = 2*AUDIO_DW sclk cycles per stereo frame.
REQ-002 sclk  input  1  the block's only clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  1 = arbitrate at frame boundaries; 0 = load silence at boundaries.
REQ-005 arb_mode  input  1  0 = fixed priority (s0 over s1); 1 = round-robin.
REQ-006 urun_mode  input  1  on underrun: 0 = output zeros; 1 = repeat last played sample.
REQ-007 s0_valid, s1_valid  input  1 each  source offers a stereo sample.
REQ-008 s0_ready, s1_ready  output  1 each  registered; high when that source's buffer is empty.
REQ-009 s0_left, s0_right, s1_left, s1_right  input  AUDIO_DW each  offered sample data.
REQ-010 left_chan, right_chan  output  AUDIO_DW each  registered sample presented to the transmitter.
REQ-011 active_src  output  2  source of current output: 00 silence, 01 s0, 10 s1, 11 repeat.
REQ-012 frame_tick  output  1  one-cycle pulse in the cycle outputs update.
REQ-013 underrun  output  1  sticky; set on any underrun at a boundary while en=1.
REQ-014 urun_clr  input  1  clears underrun and urun_cnt; clear wins over a same-cycle set.
REQ-015 urun_cnt  output  16  underrun count, saturating at 16'hFFFF.

Function
REQ-016 Free-running frame_cnt counts 0..FRAME_LEN-1 and wraps; it is never gated by en.
REQ-017 Boundary = cycle with frame_cnt==FRAME_LEN-1; left_chan/right_chan/active_src update only on the edge ending it, so they are stable for a full frame.
REQ-018 Each source has one buffer entry; transfer when sX_valid && sX_ready; sX_ready = ~full, registered (no combinational valid->ready path).
REQ-019 Boundary with en=1 and at least one full buffer: grant one source, copy its entry to outputs, mark it empty; its ready is high from the next cycle.
REQ-020 Fixed priority: s0 granted whenever full. Round-robin: both full -> grant the source not granted last; last_grant updates only on a grant.
REQ-021 Boundary with en=1 and both buffers empty: underrun; outputs per urun_mode; active_src 00 (zeros) or 11 (repeat); urun_cnt increments, underrun sets.
REQ-022 Boundary with en=0: outputs zero, active_src 00, no grant, buffers keep data, no underrun counted.
REQ-023 Buffers accept data at any frame_cnt, including the boundary cycle for a source that is not drained.
REQ-024 frame_tick is high in the cycle following every boundary, regardless of en.
REQ-025 Repeat mode keeps the last granted data even across en=0 frames; if no grant has occurred since reset, it outputs zeros.

Reset
REQ-026 Asynchronous assert on rst_n low: frame_cnt=0, buffers empty, outputs zero, active_src=00, frame_tick=0, underrun=0, urun_cnt=0, last_grant=s1 (s0 wins first round-robin tie), repeat register zero.
REQ-027 Reset mid-frame discards buffered samples; no handshake completes while rst_n is low; ready goes high on the first edge after release.

Structure
REQ-028 Shared package i2s_pkg holds the active_src encodings, the arb_mode and urun_mode encodings, and the FRAME_LEN function of AUDIO_DW.
REQ-029 One sub-module, i2s_src_buf (one-entry valid/ready buffer with drain strobe), is instantiated once per source; arbiter, frame counter and output registers stay in i2s_tx_sched.

Verification (AUDIO_DW=8, FRAME_LEN=16)
REQ-030 s0 holds (0x11,0x22) from reset, en=1, arb_mode=0 -> at cycle 16 frame_tick=1, left=0x11, right=0x22, active_src=01; s0_ready rises the cycle after.
REQ-031 Both sources always valid, arb_mode=1 -> active_src alternates 01,10,01,10 over 4 frames; with arb_mode=0 it stays 01.
REQ-032 No valid for 3 frames, urun_mode=0 -> outputs 0, active_src 00, urun_cnt=3, underrun=1; urun_clr pulse -> both 0 next cycle.
REQ-033 Play s1 (0xA5,0x5A), then starve with urun_mode=1 -> next frame repeats 0xA5/0x5A with active_src 11.
REQ-034 en=0 with both buffers full for 2 frames -> outputs zero, ready stays 0, urun_cnt unchanged; en=1 -> s0 data appears at the next boundary.
REQ-035 rst_n asserted at frame_cnt=7 with s0 full -> outputs, flags and counter clear immediately; after release, the first frame_tick occurs 16 cycles later.
